data_wbuf: RTL
==============

DATA_WBUF -- requirements
Module: data_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of write-buffer entries (power of two, 2..16).
REQ-002 SHALL have port CLK  input  1  meaning the single system clock; all logic on posedge.
REQ-003 SHALL have port RST  input  1  meaning the synchronous active-high reset, sampled on posedge CLK.
REQ-004 SHALL have port DATA_WREN  input  1  meaning the core's store request valid.
REQ-005 SHALL have port DATA_WADDR  input  32  meaning the store byte address.
REQ-006 SHALL have port DATA_WSTRB  input  4  meaning the store byte enables.
REQ-007 SHALL have port DATA_WDATA  input  32  meaning the store data.
REQ-008 SHALL have port MEM_WAIT  output  1  meaning the buffer is full and the core must hold its pipeline.
REQ-009 SHALL have port WBUF_EMPTY  output  1  meaning no entry is queued and no bus write is in flight (fence/drain indication).
REQ-010 SHALL have port WBUF_ERR  output  1  meaning a sticky flag set by a non-OKAY write response.
REQ-011 SHALL have ports M_AXI_AWADDR/AWVALID (output, 32/1) and M_AXI_AWREADY (input, 1) meaning the AXI4-Lite write address channel.
REQ-012 SHALL have ports M_AXI_WDATA/WSTRB/WVALID (output, 32/4/1) and M_AXI_WREADY (input, 1) meaning the AXI4-Lite write data channel.
REQ-013 SHALL have ports M_AXI_BRESP/BVALID (input, 2/1) and M_AXI_BREADY (output, 1) meaning the AXI4-Lite write response channel.

Function
REQ-014 SHALL push {addr, strb, data} into the FIFO on every posedge where DATA_WREN=1 and MEM_WAIT=0.
REQ-015 SHALL not accept a request while MEM_WAIT=1; the core holds the request stable until MEM_WAIT falls.
REQ-016 SHALL drive MEM_WAIT = (count == DEPTH), with count registered; a pop in the same cycle does not unblock a push until the following cycle.
REQ-017 SHALL keep read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, and count of log2(DEPTH)+1 bits.
REQ-018 SHALL allow simultaneous push and pop when not full, leaving count unchanged.
REQ-019 SHALL implement FSM IDLE -> SEND -> RESP -> IDLE.
REQ-020 IDLE: when count>0, load the head entry into AW/W output registers and go to SEND next cycle (earliest AWVALID = one cycle after push).
REQ-021 SEND: assert AWVALID and WVALID; drop each independently on its own handshake; go to RESP when both handshakes have completed (same or different cycles).
REQ-022 SHALL hold AWADDR, WDATA and WSTRB constant while the corresponding VALID is high.
REQ-023 RESP: assert BREADY; on BVALID pop the head entry, set WBUF_ERR if BRESP!=2'b00, return to IDLE.
REQ-024 SHALL have at most one AXI write outstanding; entries complete strictly in push order.
REQ-025 SHALL drive WBUF_EMPTY = (count==0) && (state==IDLE).
REQ-026 SHALL keep WBUF_ERR set until reset; an errored write is still popped (no retry).

Reset
REQ-027 SHALL, on RST, clear pointers, count, FSM to IDLE, WBUF_ERR=0, AWVALID=WVALID=BREADY=0, AWADDR/WDATA=0, WSTRB=0.
REQ-028 SHALL, on reset mid-transaction, abandon the in-flight write and all queued entries; VALIDs are low in the cycle after RST is sampled.
REQ-029 SHALL output MEM_WAIT=0 and WBUF_EMPTY=1 during and after reset.

Structure
REQ-030 SHALL place FSM state encodings and the AXI response constants (OKAY=2'b00) in the shared core package.
REQ-031 SHALL implement storage in one sub-module, sync_fifo (parameterised width 68, depth DEPTH, registered count/full/empty).

Verification
REQ-032 Single store addr 0x0000_1000, strb 4'hF, data 0xDEADBEEF, AWREADY=WREADY=1, BVALID one cycle later -> AWVALID/WVALID high one cycle after push, one B handshake, WBUF_EMPTY returns to 1.
REQ-033 Five back-to-back stores with AWREADY=0 held 20 cycles (DEPTH=4) -> MEM_WAIT rises after 4th push, 5th request accepted only after first B handshake, order on bus preserved.
REQ-034 WREADY asserted 3 cycles before AWREADY -> WVALID drops on its handshake, AWVALID stays high with stable address, BREADY only after both complete.
REQ-035 BRESP=2'b10 on the 2nd of 3 writes -> WBUF_ERR set from that cycle, 3rd write still issued, flag persists until RST.
REQ-036 RST asserted while in SEND with 2 entries queued -> VALIDs low next cycle, count=0, WBUF_EMPTY=1, MEM_WAIT=0.
REQ-037 Push and B-handshake pop in the same cycle with count=2 -> count stays 2, pointers advance by one each, wrap from DEPTH-1 to 0 verified.

Source files
------------

// File: rtl/data_wbuf_pkg.sv
// Shared types and constants for the store write buffer.
// Latency: n/a (types only).
// Backpressure: n/a.
package data_wbuf_pkg;

  // Bus-side sequencing of the head entry.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } wbuf_state_e;

  // AXI write response codes.
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // One queued store: 32-bit address, 4 byte enables, 32-bit data (68 bits).
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wbuf_entry_t;

  localparam int ENTRY_W = $bits(wbuf_entry_t);

endpackage

// File: rtl/data_wbuf_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty flags.
// Latency: a push is visible at the head one cycle later; head is read combinationally.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  // Occupancy next state; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally at DEPTH (power of two); flags are registered from count_d.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // Entry storage; contents need no reset since count gates their use.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/data_wbuf.sv
// Store write buffer: queues core stores and drains them one at a time over AXI4-Lite.
// Latency: AWVALID/WVALID rise one cycle after a store enters an idle, empty buffer.
// Backpressure: MEM_WAIT holds the core while the queue is full; one bus write outstanding.
module data_wbuf
  import data_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_WADDR,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        WBUF_EMPTY,
  output logic        WBUF_ERR,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);

  wbuf_state_e             state_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    err_q;
  logic [31:0]             awaddr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;

  wbuf_entry_t             push_ent;
  wbuf_entry_t             head_ent;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;

  assign push_ent  = '{addr: DATA_WADDR, strb: DATA_WSTRB, data: DATA_WDATA};
  assign fifo_push = DATA_WREN && !fifo_full;
  // The head is only released once its write response has been taken.
  assign fifo_pop  = (state_q == ST_RESP) && M_AXI_BVALID;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (fifo_push),
    .push_dat_i (push_ent),
    .pop_i      (fifo_pop),
    .head_dat_o (head_ent),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Bus sequencer: load head, hold AW/W until each handshakes, then take B and pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            awaddr_q  <= head_ent.addr;
            wdata_q   <= head_ent.data;
            wstrb_q   <= head_ent.strb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A channel whose VALID is already low has finished its handshake.
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            if (M_AXI_BRESP != AXI_RESP_OKAY) err_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RST forces the core-facing status immediately, before the first reset edge lands.
  assign MEM_WAIT      = fifo_full && !RST;
  assign WBUF_EMPTY    = RST || ((fifo_count == '0) && (state_q == ST_IDLE));
  assign WBUF_ERR      = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule
